// File: rtl/iq_mix_integrate_pkg.sv
// Shared widths and helpers for the IQ mixer / integrate-and-dump datapath.
package iq_mix_integrate_pkg;

    localparam int D_WIDTH_DEF   = 12;
    localparam int C_WIDTH_DEF   = 12;
    localparam int ACC_WIDTH_DEF = 40;
    localparam int SYM_LEN_W     = 16;

    // A window length of zero is treated as a single-sample window.
    function automatic logic [SYM_LEN_W-1:0] eff_len(input logic [SYM_LEN_W-1:0] len);
        return (len == '0) ? SYM_LEN_W'(1) : len;
    endfunction

endpackage

// File: rtl/iad_accum.sv
// Integrate-and-dump over a programmable number of valid samples, restartable by sym_sync.
module iad_accum
    import iq_mix_integrate_pkg::*;
#(
    parameter int IN_WIDTH  = 24,
    parameter int ACC_WIDTH = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   in_vld,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic [SYM_LEN_W-1:0]   sym_len,
    input  logic                   sym_sync,
    output logic [ACC_WIDTH-1:0]   sym_out,
    output logic                   sym_vld
);

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [SYM_LEN_W-1:0] cnt_q, cnt_d;
    logic [SYM_LEN_W-1:0] len_q, len_d;
    logic [ACC_WIDTH-1:0] sym_q, sym_d;
    logic                 sym_vld_q, sym_vld_d;

    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] sum;
    logic [SYM_LEN_W-1:0] cnt_base;
    logic [SYM_LEN_W-1:0] len_cur;

    // A sync makes the current cycle look like the start of a fresh window, so a
    // coincident sample is processed exactly as the first sample of that window.
    always_comb begin
        in_ext    = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        acc_base  = sym_sync ? '0 : acc_q;
        cnt_base  = sym_sync ? '0 : cnt_q;
        len_cur   = (cnt_base == '0) ? eff_len(sym_len) : len_q;
        sum       = acc_base + in_ext;

        acc_d     = acc_base;
        cnt_d     = cnt_base;
        len_d     = len_q;
        sym_d     = sym_q;
        sym_vld_d = 1'b0;

        if (in_vld) begin
            len_d = len_cur;
            if (cnt_base == len_cur - SYM_LEN_W'(1)) begin
                sym_d     = sum;
                sym_vld_d = 1'b1;
                acc_d     = '0;
                cnt_d     = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_base + SYM_LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            len_q     <= SYM_LEN_W'(1);
            sym_q     <= '0;
            sym_vld_q <= 1'b0;
        end else if (enable) begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sym_q     <= sym_d;
            sym_vld_q <= sym_vld_d;
        end
    end

    assign sym_out = sym_q;
    assign sym_vld = sym_vld_q;

endmodule

// File: rtl/iq_mix_integrate.sv
// Two-stage IQ mixer (data*cos, -(data*sin)) feeding per-rail integrate-and-dump.
module iq_mix_integrate
    import iq_mix_integrate_pkg::*;
#(
    parameter int D_WIDTH   = D_WIDTH_DEF,
    parameter int C_WIDTH   = C_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [D_WIDTH-1:0]           data_in,
    input  logic                         data_vld,
    input  logic [C_WIDTH-1:0]           NCO_cos,
    input  logic [C_WIDTH-1:0]           NCO_sin,
    input  logic                         NCO_vld,
    input  logic [SYM_LEN_W-1:0]         sym_len,
    input  logic                         sym_sync,
    output logic [D_WIDTH+C_WIDTH-1:0]   mix_I,
    output logic [D_WIDTH+C_WIDTH-1:0]   mix_Q,
    output logic                         mix_vld,
    output logic [ACC_WIDTH-1:0]         sym_I,
    output logic [ACC_WIDTH-1:0]         sym_Q,
    output logic                         sym_vld
);

    localparam int M_WIDTH = D_WIDTH + C_WIDTH;

    logic [D_WIDTH-1:0] data_q, data_d;
    logic [C_WIDTH-1:0] cos_q, cos_d;
    logic [C_WIDTH-1:0] sin_q, sin_d;
    logic               s1_vld_q, s1_vld_d;
    logic [M_WIDTH-1:0] mix_i_q, mix_i_d;
    logic [M_WIDTH-1:0] mix_q_q, mix_q_d;
    logic               mix_vld_q, mix_vld_d;

    logic signed [M_WIDTH-1:0] data_x, cos_x, sin_x;
    logic signed [M_WIDTH-1:0] prod_i, prod_q;
    logic                      sym_vld_i, sym_vld_qr;

    always_comb begin
        data_d   = data_in;
        cos_d    = NCO_cos;
        sin_d    = NCO_sin;
        s1_vld_d = data_vld & NCO_vld;

        // Operands widened to the full product width so the multiply is exact.
        data_x   = M_WIDTH'($signed(data_q));
        cos_x    = M_WIDTH'($signed(cos_q));
        sin_x    = M_WIDTH'($signed(sin_q));
        prod_i   = data_x * cos_x;
        prod_q   = -(data_x * sin_x);

        mix_i_d   = s1_vld_q ? prod_i : mix_i_q;
        mix_q_d   = s1_vld_q ? prod_q : mix_q_q;
        mix_vld_d = s1_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
            s1_vld_q  <= 1'b0;
            mix_i_q   <= '0;
            mix_q_q   <= '0;
            mix_vld_q <= 1'b0;
        end else if (enable) begin
            data_q    <= data_d;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
            s1_vld_q  <= s1_vld_d;
            mix_i_q   <= mix_i_d;
            mix_q_q   <= mix_q_d;
            mix_vld_q <= mix_vld_d;
        end
    end

    iad_accum #(.IN_WIDTH(M_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_iad_i (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .in_vld   (mix_vld_q),
        .in_data  (mix_i_q),
        .sym_len  (sym_len),
        .sym_sync (sym_sync),
        .sym_out  (sym_I),
        .sym_vld  (sym_vld_i)
    );

    iad_accum #(.IN_WIDTH(M_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_iad_q (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .in_vld   (mix_vld_q),
        .in_data  (mix_q_q),
        .sym_len  (sym_len),
        .sym_sync (sym_sync),
        .sym_out  (sym_Q),
        .sym_vld  (sym_vld_qr)
    );

    assign mix_I   = mix_i_q;
    assign mix_Q   = mix_q_q;
    assign mix_vld = mix_vld_q;
    // Both rails share identical window control, so their strobes always agree.
    assign sym_vld = sym_vld_i & sym_vld_qr;

endmodule

// File: doc/iq_mix_integrate.md
IQ_MIX_INTEGRATE -- requirements
Module: iq_mix_integrate

Interface
REQ-001 SHALL have parameter D_WIDTH, default 12: signed width of input sample data_in.
REQ-002 SHALL have parameter C_WIDTH, default 12: signed width of NCO_cos/NCO_sin.
REQ-003 SHALL have parameter ACC_WIDTH, default 40: signed symbol accumulator width, >= D_WIDTH+C_WIDTH+16.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 enable  input  1  clock-enable; low freezes all state and outputs.
REQ-008 data_in  input  D_WIDTH  signed ADC sample.
REQ-009 data_vld  input  1  data_in qualifier.
REQ-010 NCO_cos, NCO_sin  input  C_WIDTH each  signed carrier from the NCO cos/sin stage.
REQ-011 NCO_vld  input  1  carrier qualifier.
REQ-012 sym_len  input  16  samples per integration window, unsigned.
REQ-013 sym_sync  input  1  one-cycle pulse restarting the integration window.
REQ-014 mix_I, mix_Q  output  D_WIDTH+C_WIDTH each  signed per-sample mixer products.
REQ-015 mix_vld  output  1  mix_I/mix_Q qualifier.
REQ-016 sym_I, sym_Q  output  ACC_WIDTH each  signed integrate-and-dump results.
REQ-017 sym_vld  output  1  one-cycle strobe qualifying sym_I/sym_Q.

Function
REQ-018 All behaviour below SHALL apply only on cycles with enable=1; with enable=0 every register SHALL hold.
REQ-019 Stage 1 SHALL register data_in, NCO_cos, NCO_sin and s1_vld = data_vld & NCO_vld.
REQ-020 Stage 2 SHALL produce mix_I = data*cos and mix_Q = -(data*sin), full precision, no rounding, and mix_vld = s1_vld.
REQ-021 Mixer latency SHALL be 2 enabled cycles from input to mix_I/mix_Q/mix_vld.
REQ-022 When mix_vld=0, mix_I/mix_Q SHALL hold their previous values.
REQ-023 Integrator SHALL keep acc_I, acc_Q (ACC_WIDTH, two's-complement wrap) and cnt (16 bits), accumulating sign-extended mix_I/mix_Q on each mix_vld cycle.
REQ-024 sym_len SHALL be latched into len_q when cnt=0 and a mix_vld sample is accepted; a value of 0 SHALL be treated as 1.
REQ-025 On the mix_vld cycle where cnt = len_q-1: sym_I/sym_Q SHALL register acc+current product, sym_vld SHALL pulse 1 the next cycle, and acc/cnt SHALL clear in the same cycle.
REQ-026 Otherwise a mix_vld cycle SHALL increment cnt; sym_vld SHALL be 0 whenever not pulsing.
REQ-027 sym_I/sym_Q SHALL hold between dumps.
REQ-028 sym_sync=1 SHALL discard the partial window (no sym_vld); if mix_vld is also 1 that cycle, that product SHALL be the first sample of the new window (acc=product, cnt=1, len_q=sym_len).
REQ-029 A sym_sync coinciding with a dump cycle SHALL suppress the dump and follow REQ-028.
REQ-030 Gaps in mix_vld SHALL not advance cnt or alter acc.

Reset
REQ-031 rst=1 SHALL, regardless of enable, clear pipeline registers, mix_I, mix_Q, mix_vld, sym_I, sym_Q, sym_vld, acc_I, acc_Q and cnt to 0 and set len_q to 1.
REQ-032 Reset mid-window SHALL discard the partial window with no sym_vld; the first product after release SHALL start a new window.

Structure
REQ-033 Shared package SHALL hold default widths (D_WIDTH=12, C_WIDTH=12, ACC_WIDTH=40) and the 16-bit sym_len width constant.
REQ-034 The integrate-and-dump SHALL be one sub-module, iad_accum, instantiated twice (I and Q); the mixer pipeline SHALL stay in the top module.

Verification
REQ-035 Constant data_in=100, cos=2047, sin=0, both valids=1, sym_len=4 -> mix_I=204700, mix_Q=0 two cycles later; sym_I=818800 with sym_vld every 4th mix_vld cycle.
REQ-036 data_in=-2048, cos=-2048, sin=-2048 -> mix_I=+4194304, mix_Q=-4194304 (no overflow).
REQ-037 sym_len=8, sym_sync asserted after 5 accepted samples concurrently with mix_vld -> no sym_vld for the aborted window; next sym_vld after 8 samples counted from the sync sample.
REQ-038 sym_len=0 -> sym_vld after every mix_vld sample, sym_I equal to that sample's mix_I.
REQ-039 enable held low 10 cycles mid-window, data toggling -> all outputs frozen; window resumes with correct sum after enable returns.
REQ-040 rst pulsed mid-window with enable=0 -> all outputs 0 next cycle; first sym_vld only after a full sym_len samples post-reset.
